// File: rtl/pwm_multichannel_pkg.sv
// Shared constants and types for the multichannel PWM generator.
package pwm_multichannel_pkg;

  localparam int unsigned NUM_CH_DEF  = 16;
  localparam int unsigned CNT_W_DEF   = 8;
  localparam int unsigned PRESC_W_DEF = 8;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Duty value meaning "always high"; channels slice the low CNT_W bits (CNT_W <= 32).
  localparam logic [31:0] DUTY_FULL = '1;

  // Timebase direction states.
  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multichannel_channel.sv
// One PWM channel: duty shadow register, comparator and registered output.
module pwm_multichannel_channel
  import pwm_multichannel_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] duty_i,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic             en_out_i,
  input  logic             en_pwm_i,
  output logic             out_o
);

  logic [CNT_W-1:0] duty_sh_q;
  logic             pwm_raw;
  logic             out_q;

  // Duty shadow follows the live value only when the timebase says so.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      duty_sh_q <= '0;
    end else if (load_i) begin
      duty_sh_q <= duty_i;
    end
  end

  // Compare: all-ones duty is forced high so the full-scale value gives 100 %.
  always_comb begin
    pwm_raw = enable_i & ((duty_sh_q == DUTY_FULL[CNT_W-1:0]) | (cnt_i < duty_sh_q));
  end

  // Output gating; en_pwm=0 turns an enabled channel into a static high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= 1'b0;
    end else begin
      out_q <= en_out_i & (en_pwm_i ? pwm_raw : 1'b1);
    end
  end

  assign out_o = out_q;

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator: prescaler, shared up/up-down timebase, shadowed period/mode.
//
// state   | meaning
// ST_UP   | counter rising (edge mode always stays here)
// ST_DOWN | centre mode, counter falling back towards 0
module pwm_multichannel
  import pwm_multichannel_pkg::*;
#(
  parameter int unsigned NUM_CH  = NUM_CH_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned PRESC_W = PRESC_W_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    center_mode_i,
  input  logic [PRESC_W-1:0]      prescale_i,
  input  logic [CNT_W-1:0]        period_i,
  input  logic [NUM_CH*CNT_W-1:0] duty_flat_i,
  input  logic [NUM_CH-1:0]       en_out_i,
  input  logic [NUM_CH-1:0]       en_pwm_i,
  output logic [NUM_CH-1:0]       out_o,
  output logic                    period_strb_o
);

  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   period_sh_q;
  logic               mode_sh_q;
  logic               strb_q;
  dir_e               state_q, state_d;
  logic               tick;
  logic               boundary;
  logic               load;

  // Prescaler: tick on terminal count, held at zero while disabled.
  always_comb begin
    tick        = 1'b0;
    presc_cnt_d = presc_cnt_q;
    if (!enable_i) begin
      presc_cnt_d = '0;
    end else if (presc_cnt_q == prescale_i) begin
      tick        = 1'b1;
      presc_cnt_d = '0;
    end else begin
      presc_cnt_d = presc_cnt_q + PRESC_W'(1);
    end
  end

  // Timebase next state; centre mode with period 0 falls back to edge behaviour.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    boundary = 1'b0;
    if (!enable_i) begin
      state_d = ST_UP;
      cnt_d   = '0;
    end else if (tick) begin
      if ((mode_sh_q == MODE_CENTER) && (period_sh_q != '0)) begin
        unique case (state_q)
          ST_UP: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d >= period_sh_q) state_d = ST_DOWN;
          end
          ST_DOWN: begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d    = '0;
              state_d  = ST_UP;
              boundary = 1'b1;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        endcase
      end else begin
        state_d = ST_UP;
        if (cnt_q >= period_sh_q) begin
          cnt_d    = '0;
          boundary = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // Shadows are transparent while disabled so a restart picks up current settings.
  assign load = ~enable_i | boundary;

  // Timebase, prescaler and direction registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_cnt_q <= '0;
      cnt_q       <= '0;
      state_q     <= ST_UP;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
    end
  end

  // Period/mode shadows and the boundary strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      period_sh_q <= '0;
      mode_sh_q   <= MODE_EDGE;
      strb_q      <= 1'b0;
    end else begin
      strb_q <= boundary;
      if (load) begin
        period_sh_q <= period_i;
        mode_sh_q   <= center_mode_i;
      end
    end
  end

  assign period_strb_o = strb_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_multichannel_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .cnt_i    (cnt_q),
      .duty_i   (duty_flat_i[i*CNT_W +: CNT_W]),
      .load_i   (load),
      .enable_i (enable_i),
      .en_out_i (en_out_i[i]),
      .en_pwm_i (en_pwm_i[i]),
      .out_o    (out_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel with a phase-based reference model.
module tb_pwm_multichannel;

  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;
  localparam int FULL    = (1 << CNT_W) - 1;

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    enable_i;
  logic                    center_mode_i;
  logic [PRESC_W-1:0]      prescale_i;
  logic [CNT_W-1:0]        period_i;
  logic [NUM_CH*CNT_W-1:0] duty_flat_i;
  logic [NUM_CH-1:0]       en_out_i;
  logic [NUM_CH-1:0]       en_pwm_i;
  logic [NUM_CH-1:0]       out_o;
  logic                    period_strb_o;

  int n_assert;
  int n_fail;

  pwm_multichannel #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .enable_i     (enable_i),
    .center_mode_i(center_mode_i),
    .prescale_i   (prescale_i),
    .period_i     (period_i),
    .duty_flat_i  (duty_flat_i),
    .en_out_i     (en_out_i),
    .en_pwm_i     (en_pwm_i),
    .out_o        (out_o),
    .period_strb_o(period_strb_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: position within the period as a phase index, counter derived from it.
  int              m_presc;
  int              m_phase;
  int              m_per;
  bit              m_mode;
  int              m_duty[NUM_CH];
  logic [NUM_CH-1:0] m_out;
  logic            m_strb;

  function automatic int plen();
    if (m_per == 0) return 1;
    return m_mode ? 2 * m_per : m_per + 1;
  endfunction

  function automatic int cur_cnt();
    if (m_mode && m_per != 0 && m_phase > m_per) return 2 * m_per - m_phase;
    return m_phase;
  endfunction

  function automatic int duty_of(int i);
    return int'(duty_flat_i[i*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    m_presc = 0; m_phase = 0; m_per = 0; m_mode = 0;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
    m_out = '0; m_strb = 1'b0;
  endtask

  task automatic model_load();
    m_per  = int'(period_i);
    m_mode = center_mode_i;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = duty_of(i);
  endtask

  task automatic model_edge();
    if (!enable_i) begin
      m_out = en_out_i & ~en_pwm_i;
      m_presc = 0; m_phase = 0; m_strb = 1'b0;
      model_load();
    end else begin
      int c;
      c = cur_cnt();
      for (int i = 0; i < NUM_CH; i++) begin
        bit raw;
        raw = (m_duty[i] == FULL) || (c < m_duty[i]);
        m_out[i] = en_out_i[i] & (en_pwm_i[i] ? raw : 1'b1);
      end
      m_strb = 1'b0;
      if (m_presc == int'(prescale_i)) begin
        m_presc = 0;
        m_phase = (m_phase + 1) % plen();
        if (m_phase == 0) begin
          model_load();
          m_strb = 1'b1;
        end
      end else begin
        m_presc = (m_presc + 1) % (1 << PRESC_W);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_ni) model_edge();
    #1;
  endtask

  task automatic set_duty(int ch, int v);
    duty_flat_i[ch*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic sync_strb(output bit ok);
    ok = 1'b0;
    cycle();
    for (int k = 0; k < 600; k++) begin
      if (period_strb_o) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
  endtask

  task automatic test_reset();
    #2;
    n_assert++;
    if (out_o !== '0 || period_strb_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_init got out=%h strb=%b exp 0/0", out_o, period_strb_o);
    end
    enable_i = 1'b1; center_mode_i = 1'b0; prescale_i = '0; period_i = 8'd9;
    for (int i = 0; i < NUM_CH; i++) set_duty(i, 3);
    en_out_i = '1; en_pwm_i = '0;
    #1 rst_ni = 1'b1;
    cycle();
    n_assert++;
    if (out_o !== '1) begin
      n_fail++; $display("FAIL static_high got %h exp %h", out_o, {NUM_CH{1'b1}});
    end
    en_pwm_i = 16'h00FF;
    repeat (23) begin
      cycle();
      n_assert++;
      if (out_o !== m_out) begin
        n_fail++; $display("FAIL reset_run t=%0t got %h exp %h", $time, out_o, m_out);
      end
    end
    #3 rst_ni = 1'b0;
    #1;
    n_assert++;
    if (out_o !== '0 || period_strb_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_async got out=%h strb=%b exp 0/0", out_o, period_strb_o);
    end
    model_reset();
    repeat (3) begin
      cycle();
      n_assert++;
      if (out_o !== '0 || period_strb_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold got out=%h strb=%b exp 0/0", out_o, period_strb_o);
      end
    end
    en_pwm_i = '0;
    #3 rst_ni = 1'b1;
    cycle();
    n_assert++;
    if (out_o !== '1) begin
      n_fail++; $display("FAIL release_static got %h exp %h", out_o, {NUM_CH{1'b1}});
    end
  endtask

  task automatic test_edge_duty();
    bit ok;
    int hi;
    en_out_i = '1; en_pwm_i = '1; center_mode_i = 1'b0; prescale_i = '0; period_i = 8'd9;
    for (int i = 1; i < NUM_CH; i++) set_duty(i, $urandom_range(0, 9));
    set_duty(0, 3);
    sync_strb(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL edge_sync got no strobe exp strobe"); end
    for (int p = 0; p < 3; p++) begin
      hi = 0;
      for (int j = 1; j <= 10; j++) begin
        cycle();
        hi += int'(out_o[0]);
        n_assert++;
        if (out_o !== m_out) begin
          n_fail++; $display("FAIL edge_out t=%0t got %h exp %h", $time, out_o, m_out);
        end
        n_assert++;
        if (period_strb_o !== (j == 10)) begin
          n_fail++; $display("FAIL edge_strb j=%0d got %b exp %b", j, period_strb_o, (j == 10));
        end
      end
      n_assert++;
      if (hi != 3) begin n_fail++; $display("FAIL edge_high got %0d exp 3", hi); end
    end
  endtask

  task automatic test_extremes();
    bit ok;
    set_duty(0, 0); set_duty(1, FULL); set_duty(2, 12);
    sync_strb(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL ext_sync got no strobe exp strobe"); end
    repeat (20) begin
      cycle();
      n_assert++;
      if (out_o[2:0] !== 3'b110) begin
        n_fail++; $display("FAIL extremes got %b exp 110", out_o[2:0]);
      end
      n_assert++;
      if (out_o !== m_out) begin
        n_fail++; $display("FAIL ext_out got %h exp %h", out_o, m_out);
      end
    end
  endtask

  task automatic test_shadowing();
    bit ok;
    int hi;
    int exp_hi[3] = '{3, 7, 7};
    int len[3] = '{10, 10, 15};
    set_duty(0, 3);
    sync_strb(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL shadow_sync got no strobe exp strobe"); end
    for (int w = 0; w < 3; w++) begin
      hi = 0;
      for (int j = 1; j <= len[w]; j++) begin
        cycle();
        if (w == 0 && j == 5) set_duty(0, 7);
        if (w == 1 && j == 4) period_i = 8'd14;
        hi += int'(out_o[0]);
        n_assert++;
        if (out_o !== m_out) begin
          n_fail++; $display("FAIL shadow_out t=%0t got %h exp %h", $time, out_o, m_out);
        end
        n_assert++;
        if (period_strb_o !== (j == len[w])) begin
          n_fail++; $display("FAIL shadow_strb w=%0d j=%0d got %b exp %b", w, j, period_strb_o, (j == len[w]));
        end
      end
      n_assert++;
      if (hi != exp_hi[w]) begin
        n_fail++; $display("FAIL shadow_high w=%0d got %0d exp %0d", w, hi, exp_hi[w]);
      end
    end
  endtask

  task automatic test_centre();
    bit ok;
    int hi;
    int hist[17];
    center_mode_i = 1'b1; period_i = 8'd4; prescale_i = 8'd1; set_duty(0, 2);
    sync_strb(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL centre_sync got no strobe exp strobe"); end
    hi = 0;
    for (int j = 1; j <= 16; j++) begin
      cycle();
      hist[j] = int'(out_o[0]);
      hi += hist[j];
      n_assert++;
      if (out_o !== m_out) begin
        n_fail++; $display("FAIL centre_out t=%0t got %h exp %h", $time, out_o, m_out);
      end
      n_assert++;
      if (period_strb_o !== (j == 16)) begin
        n_fail++; $display("FAIL centre_strb j=%0d got %b exp %b", j, period_strb_o, (j == 16));
      end
    end
    // cnt<2 holds at counts 0, 1 (rising) and 1 (falling): 3 ticks of 2 clks.
    n_assert++;
    if (hi != 6) begin n_fail++; $display("FAIL centre_high got %0d exp 6", hi); end
    for (int p = 1; p < 8; p++) begin
      n_assert++;
      if (hist[2*p+1] != hist[2*(8-p)+1]) begin
        n_fail++; $display("FAIL centre_sym phase %0d got %0d exp %0d", p, hist[2*p+1], hist[2*(8-p)+1]);
      end
    end
  endtask

  task automatic test_prescaler_enable();
    bit ok;
    int hi;
    int first;
    center_mode_i = 1'b0; prescale_i = 8'd3; period_i = 8'd9; set_duty(0, 3);
    sync_strb(ok);
    n_assert++;
    if (!ok) begin n_fail++; $display("FAIL presc_sync got no strobe exp strobe"); end
    for (int r = 0; r < 2; r++) begin
      hi = 0; first = 0;
      for (int j = 1; j <= 40; j++) begin
        cycle();
        hi += int'(out_o[0]);
        if (period_strb_o && first == 0) first = j;
        n_assert++;
        if (out_o !== m_out) begin
          n_fail++; $display("FAIL presc_out t=%0t got %h exp %h", $time, out_o, m_out);
        end
      end
      n_assert++;
      if (first != 40) begin n_fail++; $display("FAIL presc_strb r=%0d got %0d exp 40", r, first); end
      n_assert++;
      if (hi != 12) begin n_fail++; $display("FAIL presc_high r=%0d got %0d exp 12", r, hi); end
      if (r == 0) begin
        enable_i = 1'b0;
        repeat (5) begin
          cycle();
          n_assert++;
          if (out_o !== '0 || period_strb_o !== 1'b0) begin
            n_fail++; $display("FAIL disable got out=%h strb=%b exp 0/0", out_o, period_strb_o);
          end
        end
        enable_i = 1'b1;
      end
    end
  endtask

  task automatic test_random();
    int sel;
    int ch;
    int r;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        sel = $urandom_range(0, 7);
        case (sel)
          0: period_i = CNT_W'($urandom_range(0, 12));
          1, 7: begin
            ch = $urandom_range(0, NUM_CH - 1);
            r = $urandom_range(0, 9);
            set_duty(ch, (r == 0) ? 0 : (r == 1) ? FULL : $urandom_range(0, 14));
          end
          2: center_mode_i = 1'($urandom_range(0, 1));
          3: if ($urandom_range(0, 3) == 0) prescale_i = PRESC_W'($urandom_range(0, 2));
          4: enable_i = ($urandom_range(0, 3) != 0);
          5: en_out_i = NUM_CH'($urandom);
          default: en_pwm_i = NUM_CH'($urandom);
        endcase
      end
      cycle();
      n_assert++;
      if (out_o !== m_out) begin
        n_fail++; $display("FAIL rand_out t=%0t got %h exp %h", $time, out_o, m_out);
      end
      n_assert++;
      if (period_strb_o !== m_strb) begin
        n_fail++; $display("FAIL rand_strb t=%0t got %b exp %b", $time, period_strb_o, m_strb);
      end
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst_ni = 1'b0; enable_i = 1'b0; center_mode_i = 1'b0; prescale_i = '0; period_i = '0;
    duty_flat_i = '0; en_out_i = '0; en_pwm_i = '0;
    model_reset();
    test_reset();
    test_edge_duty();
    test_extremes();
    test_shadowing();
    test_centre();
    test_prescaler_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
